// File: rtl/etapa_mem_pkg.sv
// etapa_mem_pkg: access-size codes, MEM-stage FSM states and load extension helper
package etapa_mem_pkg;

    localparam logic [1:0] TAM_WORD = 2'b00;
    localparam logic [1:0] TAM_BYTE = 2'b01;
    localparam logic [1:0] TAM_HALF = 2'b10;
    localparam logic [1:0] TAM_INV  = 2'b11;

    localparam logic [0:0] LIMPIAR = 1'b0;
    localparam logic [0:0] OPERAR  = 1'b1;

    function automatic logic [31:0] extender(
        input logic [31:0] w,
        input logic [1:0]  lane,
        input logic [1:0]  tam,
        input logic        signo
    );
        logic [31:0] s;
        s = w >> {lane, 3'b000};
        return tam == TAM_BYTE ? {{24{signo & s[7]}}, s[7:0]} :
               tam == TAM_HALF ? {{16{signo & s[15]}}, s[15:0]} : w;
    endfunction

endpackage

// File: rtl/memoria_datos_ram.sv
// memoria_datos_ram: single-port byte-enabled read-first data RAM with a registered debug read port
module memoria_datos_ram #(
    parameter int NBITS = 32,
    parameter int PROF  = 256
) (
    input  logic                     clk,
    input  logic                     re,
    input  logic [3:0]               we,
    input  logic [$clog2(PROF)-1:0]  addr,
    input  logic [NBITS-1:0]         din,
    output logic [NBITS-1:0]         dout,
    input  logic [$clog2(PROF)-1:0]  dbg_addr,
    output logic [NBITS-1:0]         dbg_dout
);

    logic [NBITS-1:0] mem [PROF];

    // byte-lane writes; both read ports see the pre-write contents
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (we[b]) mem[addr][8*b +: 8] <= din[8*b +: 8];
        if (re) dout <= mem[addr];
        dbg_dout <= mem[dbg_addr];
    end

endmodule

// File: rtl/etapa_mem.sv
// etapa_mem: MEM pipeline stage with memory clearing, alignment checks and load extension
module etapa_mem
    import etapa_mem_pkg::*;
#(
    parameter int NBITS  = 32,
    parameter int TNBITS = 2,
    parameter int RBITS  = 5,
    parameter int PROF   = 256
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_Enable,
    input  logic                     i_MemWrite,
    input  logic                     i_MemRead,
    input  logic [TNBITS-1:0]        i_Tamano,
    input  logic                     i_Signo,
    input  logic [NBITS-1:0]         i_Direccion,
    input  logic [NBITS-1:0]         i_DatoEscribir,
    input  logic                     i_RegWrite,
    input  logic                     i_MemtoReg,
    input  logic [RBITS-1:0]         i_RegDest,
    input  logic [$clog2(PROF)-1:0]  i_DebugDir,
    output logic [NBITS-1:0]         o_DatoLeido,
    output logic [NBITS-1:0]         o_ResultadoALU,
    output logic                     o_RegWrite,
    output logic                     o_MemtoReg,
    output logic [RBITS-1:0]         o_RegDest,
    output logic [NBITS-1:0]         o_DebugDato,
    output logic                     o_Listo,
    output logic                     o_ErrorAlineacion
);

    localparam int AW = $clog2(PROF);

    logic [0:0]       estado;
    logic [AW-1:0]    cnt;
    logic [1:0]       tam, lane, lane_q, tam_q;
    logic             signo_q, carga_q;
    logic             operar, avanza, acceso, falla, lee;
    logic [3:0]       be_op, be;
    logic [AW-1:0]    ram_dir;
    logic [NBITS-1:0] din_op, ram_din, rd_dato;

    // decode the access: fault detection, lane enables and replicated store data
    always_comb begin
        tam     = i_Tamano[1:0];
        lane    = i_Direccion[1:0];
        operar  = estado == OPERAR;
        avanza  = operar & i_Enable;
        acceso  = avanza & (i_MemWrite | i_MemRead);
        falla   = (tam == TAM_INV) | (tam == TAM_WORD & lane != 2'b00) | (tam == TAM_HALF & lane[0]);
        lee     = avanza;
        be_op   = tam == TAM_WORD ? 4'hF : tam == TAM_HALF ? (lane[1] ? 4'hC : 4'h3) : 4'b0001 << lane;
        din_op  = tam == TAM_WORD ? i_DatoEscribir :
                  tam == TAM_HALF ? {2{i_DatoEscribir[15:0]}} : {4{i_DatoEscribir[7:0]}};
        be      = operar ? ((acceso & i_MemWrite & !falla) ? be_op : 4'h0) : 4'hF;
        ram_dir = operar ? i_Direccion[AW+1:2] : cnt;
        ram_din = operar ? din_op : '0;
    end

    memoria_datos_ram #(.NBITS(NBITS), .PROF(PROF)) u_ram (
        .clk      (i_clk),
        .re       (lee),
        .we       (be),
        .addr     (ram_dir),
        .din      (ram_din),
        .dout     (rd_dato),
        .dbg_addr (i_DebugDir),
        .dbg_dout (o_DebugDato)
    );

    assign o_Listo     = estado == OPERAR;
    assign o_DatoLeido = carga_q ? NBITS'(extender(32'(rd_dato), lane_q, tam_q, signo_q)) : '0;

    // clear sequencing, MEM/WB pipeline register and sticky fault flag
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            estado            <= LIMPIAR;
            cnt               <= '0;
            o_ErrorAlineacion <= 1'b0;
            o_ResultadoALU    <= '0;
            o_RegWrite        <= 1'b0;
            o_MemtoReg        <= 1'b0;
            o_RegDest         <= '0;
            carga_q           <= 1'b0;
            lane_q            <= '0;
            tam_q             <= '0;
            signo_q           <= 1'b0;
        end else begin
            if (!operar) begin
                cnt <= cnt == AW'(PROF - 1) ? cnt : cnt + 1'b1;
                if (cnt == AW'(PROF - 1)) estado <= OPERAR;
            end
            if (avanza) begin
                o_ResultadoALU <= i_Direccion;
                o_RegWrite     <= i_RegWrite & !((i_MemWrite | i_MemRead) & falla);
                o_MemtoReg     <= i_MemtoReg;
                o_RegDest      <= i_RegDest;
                carga_q        <= i_MemRead & !i_MemWrite & !falla;
                lane_q         <= lane;
                tam_q          <= tam;
                signo_q        <= i_Signo;
            end
            if (acceso & falla) o_ErrorAlineacion <= 1'b1;
        end
    end

endmodule

// File: tb/tb_etapa_mem.sv
// tb_etapa_mem: randomized and directed checks of etapa_mem against a byte-array memory model
module tb_etapa_mem;

    localparam int NBITS = 32, TNBITS = 2, RBITS = 5, PROF = 256, AW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              en, wr, rd, sg, rw, mtr;
    logic [1:0]        tm;
    logic [31:0]       dir, dato;
    logic [4:0]        dst;
    logic [AW-1:0]     ddir;
    logic [31:0]       o_dato, o_alu, o_dbg;
    logic              o_rw, o_mtr, o_listo, o_err;
    logic [4:0]        o_dst;

    int checks = 0, errors = 0;
    logic [7:0] mb [PROF*4];

    always #5 clk = ~clk;

    etapa_mem #(.NBITS(NBITS), .TNBITS(TNBITS), .RBITS(RBITS), .PROF(PROF)) dut (
        .i_clk(clk), .i_reset(rst), .i_Enable(en), .i_MemWrite(wr), .i_MemRead(rd),
        .i_Tamano(tm), .i_Signo(sg), .i_Direccion(dir), .i_DatoEscribir(dato),
        .i_RegWrite(rw), .i_MemtoReg(mtr), .i_RegDest(dst), .i_DebugDir(ddir),
        .o_DatoLeido(o_dato), .o_ResultadoALU(o_alu), .o_RegWrite(o_rw), .o_MemtoReg(o_mtr),
        .o_RegDest(o_dst), .o_DebugDato(o_dbg), .o_Listo(o_listo), .o_ErrorAlineacion(o_err)
    );

    function automatic bit is_fault(input logic [31:0] a, input logic [1:0] t);
        return t == 2'b11 || (t == 2'b10 && a[0]) || (t == 2'b00 && a[1:0] != 2'b00);
    endfunction

    function automatic int nbytes(input logic [1:0] t);
        return t == 2'b00 ? 4 : t == 2'b01 ? 1 : 2;
    endfunction

    function automatic logic [31:0] mdl_load(input logic [31:0] a, input logic [1:0] t, input bit s);
        int base = int'(a[9:0]);
        int n = nbytes(t);
        logic [31:0] v = 0;
        for (int i = 0; i < n; i++) v |= 32'(mb[base + i]) << (8 * i);
        if (s && n < 4 && v[8*n-1]) v |= ~((32'd1 << (8 * n)) - 1);
        return v;
    endfunction

    task automatic mdl_store(input logic [31:0] a, input logic [1:0] t, input logic [31:0] d);
        int base = int'(a[9:0]);
        for (int i = 0; i < nbytes(t); i++) mb[base + i] = d[8*i +: 8];
    endtask

    function automatic logic [31:0] mdl_word(input int k);
        return {mb[4*k+3], mb[4*k+2], mb[4*k+1], mb[4*k]};
    endfunction

    task automatic drive(input bit e, w, r, input logic [1:0] t, input bit s,
                         input logic [31:0] a, d, input bit regw, mreg, input logic [4:0] rdst);
        en = e; wr = w; rd = r; tm = t; sg = s; dir = a; dato = d; rw = regw; mtr = mreg; dst = rdst;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        drive(1, 0, 0, 2'b00, 0, 32'h0, 32'h0, 0, 0, 5'd0);
    endtask

    task automatic do_reset();
        rst = 1; en = 0; wr = 0; rd = 0; tm = 0; sg = 0; dir = 0; dato = 0; rw = 0; mtr = 0; dst = 0; ddir = 0;
        for (int i = 0; i < PROF * 4; i++) mb[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic wait_listo(output int n);
        n = 0;
        while (o_listo !== 1'b1 && n < PROF + 50) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        do_reset();
        checks++; if (o_listo !== 1'b0) begin errors++; $display("FAIL reset_listo got %0b want 0", o_listo); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", o_err); end
        checks++; if ({o_dato, o_alu, o_rw, o_mtr, o_dst} !== '0) begin errors++;
            $display("FAIL reset_outputs got dato=%h alu=%h rw=%b mtr=%b dst=%0d want all 0", o_dato, o_alu, o_rw, o_mtr, o_dst); end
        wait_listo(n);
        checks++; if (n !== PROF) begin errors++; $display("FAIL listo_latency got %0d want %0d", n, PROF); end
        for (int k = 0; k < PROF; k++) begin
            ddir = AW'(k);
            @(posedge clk); #1;
            checks++; if (o_dbg !== 32'h0) begin errors++; $display("FAIL clear_scan word %0d got %h want 0", k, o_dbg); end
        end
    endtask

    task automatic test_store_load();
        drive(1, 1, 0, 2'b00, 0, 32'h10, 32'hDEADBEEF, 1, 0, 5'd1); mdl_store(32'h10, 2'b00, 32'hDEADBEEF);
        checks++; if (o_dato !== 32'h0 || o_rw !== 1'b1) begin errors++; $display("FAIL sw_outputs got dato=%h rw=%b want 0/1", o_dato, o_rw); end
        drive(1, 1, 0, 2'b01, 0, 32'h11, 32'h000000AA, 0, 0, 5'd0); mdl_store(32'h11, 2'b01, 32'hAA);
        drive(1, 0, 1, 2'b00, 0, 32'h10, 32'h0, 1, 1, 5'd2);
        checks++; if (o_dato !== 32'hDEADAAEF) begin errors++; $display("FAIL lw_after_sb got %h want deadaaef", o_dato); end
        drive(1, 0, 1, 2'b01, 1, 32'h13, 32'h0, 1, 1, 5'd2);
        checks++; if (o_dato !== 32'hFFFFFFDE) begin errors++; $display("FAIL lb got %h want ffffffde", o_dato); end
        drive(1, 0, 1, 2'b01, 0, 32'h13, 32'h0, 1, 1, 5'd2);
        checks++; if (o_dato !== 32'h000000DE) begin errors++; $display("FAIL lbu got %h want 000000de", o_dato); end
        drive(1, 0, 1, 2'b10, 1, 32'h12, 32'h0, 1, 1, 5'd2);
        checks++; if (o_dato !== 32'hFFFFDEAD) begin errors++; $display("FAIL lh got %h want ffffdead", o_dato); end
        drive(1, 0, 1, 2'b10, 0, 32'h10, 32'h0, 1, 1, 5'd2);
        checks++; if (o_dato !== 32'h0000AAEF) begin errors++; $display("FAIL lhu got %h want 0000aaef", o_dato); end
        idle();
        checks++; if (o_dato !== 32'h0) begin errors++; $display("FAIL non_load_zero got %h want 0", o_dato); end
        ddir = 8'd4;
        drive(1, 1, 0, 2'b00, 0, 32'h10, 32'h11112222, 0, 0, 5'd0); mdl_store(32'h10, 2'b00, 32'h11112222);
        checks++; if (o_dbg !== 32'hDEADAAEF) begin errors++; $display("FAIL debug_read_first got %h want deadaaef", o_dbg); end
        idle();
        checks++; if (o_dbg !== 32'h11112222) begin errors++; $display("FAIL debug_after_write got %h want 11112222", o_dbg); end
        drive(1, 1, 1, 2'b00, 0, 32'h14, 32'h00000055, 1, 0, 5'd3); mdl_store(32'h14, 2'b00, 32'h55);
        checks++; if (o_dato !== 32'h0) begin errors++; $display("FAIL wr_rd_both got %h want 0", o_dato); end
        drive(1, 0, 1, 2'b00, 0, 32'h14, 32'h0, 1, 0, 5'd3);
        checks++; if (o_dato !== 32'h00000055) begin errors++; $display("FAIL wr_rd_both_wrote got %h want 00000055", o_dato); end
    endtask

    task automatic test_stall();
        drive(1, 0, 1, 2'b00, 0, 32'h10, 32'h0, 1, 1, 5'd7);
        ddir = 8'd12;
        drive(0, 1, 0, 2'b00, 0, 32'h30, 32'h12345678, 0, 0, 5'd3);
        checks++; if (o_dato !== 32'h11112222 || o_alu !== 32'h10 || o_rw !== 1'b1 || o_mtr !== 1'b1 || o_dst !== 5'd7) begin errors++;
            $display("FAIL stall_hold got dato=%h alu=%h rw=%b mtr=%b dst=%0d want 11112222/10/1/1/7", o_dato, o_alu, o_rw, o_mtr, o_dst); end
        drive(0, 1, 0, 2'b00, 0, 32'h30, 32'h12345678, 0, 0, 5'd3);
        checks++; if (o_dbg !== 32'h0) begin errors++; $display("FAIL stall_no_write got %h want 0", o_dbg); end
        drive(1, 1, 0, 2'b00, 0, 32'h30, 32'h12345678, 0, 0, 5'd3); mdl_store(32'h30, 2'b00, 32'h12345678);
        checks++; if (o_alu !== 32'h30 || o_dato !== 32'h0 || o_dst !== 5'd3) begin errors++;
            $display("FAIL enable_advance got alu=%h dato=%h dst=%0d want 30/0/3", o_alu, o_dato, o_dst); end
        idle();
        checks++; if (o_dbg !== 32'h12345678) begin errors++; $display("FAIL enable_write got %h want 12345678", o_dbg); end
    endtask

    task automatic test_fault();
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL err_before_fault got %b want 0", o_err); end
        ddir = 8'd8;
        drive(1, 1, 0, 2'b10, 0, 32'h21, 32'h0000BEEF, 1, 0, 5'd4);
        checks++; if (o_rw !== 1'b0 || o_err !== 1'b1) begin errors++; $display("FAIL sh_misaligned got rw=%b err=%b want 0/1", o_rw, o_err); end
        idle();
        checks++; if (o_dbg !== 32'h0) begin errors++; $display("FAIL sh_no_write got %h want 0", o_dbg); end
        drive(1, 0, 1, 2'b00, 0, 32'h10, 32'h0, 1, 0, 5'd5);
        checks++; if (o_rw !== 1'b1 || o_err !== 1'b1 || o_dato !== 32'h11112222) begin errors++;
            $display("FAIL err_sticky got rw=%b err=%b dato=%h want 1/1/11112222", o_rw, o_err, o_dato); end
        drive(1, 0, 1, 2'b00, 0, 32'h12, 32'h0, 1, 0, 5'd5);
        checks++; if (o_rw !== 1'b0 || o_dato !== 32'h0) begin errors++; $display("FAIL lw_misaligned got rw=%b dato=%h want 0/0", o_rw, o_dato); end
        drive(1, 0, 1, 2'b11, 0, 32'h10, 32'h0, 1, 0, 5'd5);
        checks++; if (o_rw !== 1'b0) begin errors++; $display("FAIL size_invalid got rw=%b want 0", o_rw); end
    endtask

    task automatic test_reset_midclear();
        int n;
        do_reset();
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_clears_err got %b want 0", o_err); end
        for (int i = 0; i < 100; i++) begin
            drive(1, i[0], 1, 2'b00, 0, 32'h40, 32'hFFFFFFFF, 1, 1, 5'd9);
            if (i % 20 == 0) begin
                checks++; if (o_listo !== 1'b0 || o_dato !== 32'h0 || o_rw !== 1'b0 || o_alu !== 32'h0) begin errors++;
                    $display("FAIL clear_ignores got listo=%b dato=%h rw=%b alu=%h want 0", o_listo, o_dato, o_rw, o_alu); end
            end
        end
        do_reset();
        wait_listo(n);
        checks++; if (n !== PROF) begin errors++; $display("FAIL restart_latency got %0d want %0d", n, PROF); end
    endtask

    task automatic test_random();
        logic [31:0] e_dato = 0, e_alu = 0, a, d;
        logic        e_rw = 0, e_mtr = 0, e_err = 0, bad;
        logic [4:0]  e_dst = 0;
        logic [1:0]  t;
        bit          ee, ww, rr, ss, rg, mt;
        logic [4:0]  ds;
        idle();
        for (int i = 0; i < 400; i++) begin
            ee = $urandom_range(0, 9) != 0;
            ww = $urandom_range(0, 1) != 0;
            rr = $urandom_range(0, 1) != 0;
            t  = $urandom_range(0, 15) == 0 ? 2'b11 : 2'($urandom_range(0, 2));
            ss = $urandom_range(0, 1) != 0;
            a  = ($urandom & 32'hFFFFFC00) | 32'($urandom_range(0, 63));
            d  = $urandom;
            d  = t == 2'b01 ? d & 32'hFF : t == 2'b10 ? d & 32'hFFFF : d;
            rg = $urandom_range(0, 1) != 0;
            mt = $urandom_range(0, 1) != 0;
            ds = 5'($urandom);
            if (ee) begin
                bad    = (ww || rr) && is_fault(a, t);
                e_dato = (rr && !ww && !bad) ? mdl_load(a, t, ss) : 32'h0;
                if (ww && !bad) mdl_store(a, t, d);
                e_rw   = rg && !bad;
                e_mtr  = mt;
                e_dst  = ds;
                e_alu  = a;
                e_err  = e_err | bad;
            end
            drive(ee, ww, rr, t, ss, a, d, rg, mt, ds);
            checks++; if (o_dato !== e_dato || o_alu !== e_alu || o_rw !== e_rw || o_mtr !== e_mtr || o_dst !== e_dst || o_err !== e_err) begin
                errors++;
                $display("FAIL random step %0d got dato=%h alu=%h rw=%b mtr=%b dst=%0d err=%b want %h %h %b %b %0d %b",
                         i, o_dato, o_alu, o_rw, o_mtr, o_dst, o_err, e_dato, e_alu, e_rw, e_mtr, e_dst, e_err);
            end
        end
        for (int k = 0; k < 16; k++) begin
            ddir = AW'(k);
            @(posedge clk); #1;
            checks++; if (o_dbg !== mdl_word(k)) begin errors++; $display("FAIL random_scan word %0d got %h want %h", k, o_dbg, mdl_word(k)); end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_stall();
        test_fault();
        test_reset_midclear();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
